// File: rtl/reaction_round_scheduler_if.sv
// reaction_round_scheduler_if: button, hit-zone and display signals between the game board and the round scheduler.
interface reaction_round_scheduler_if;
    logic       start_n;
    logic [1:0] btn_n;
    logic       hit_zone;
    logic       led_step;
    logic       led_restart;
    logic       blink_mode;
    logic [3:0] level;
    logic [3:0] score0;
    logic [3:0] score1;
    logic       win;
    logic       winner;

    modport master (
        output start_n, btn_n, hit_zone,
        input  led_step, led_restart, blink_mode, level, score0, score1, win, winner
    );

    modport slave (
        input  start_n, btn_n, hit_zone,
        output led_step, led_restart, blink_mode, level, score0, score1, win, winner
    );
endinterface

// File: rtl/reaction_round_scheduler.sv
// reaction_round_scheduler: round FSM, LED sweep timing, button arbitration and scoring for the two-player reaction game.
// Optional feature macro REACTION_TIE_ROUND_ROBIN_EN: simultaneous valid hits alternate between players instead of always going to P0.
module reaction_round_scheduler #(
    parameter int TICK_BASE   = 5000000,
    parameter int TICK_STEP   = 500000,
    parameter int NUM_LEVELS  = 9,
    parameter int DEBOUNCE    = 20000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int WIN_SCORE   = 5
) (
    input logic CLOCK,
    input logic RESET_N,
    reaction_round_scheduler_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [3:0] LVL_TOP = 4'(NUM_LEVELS - 1);
    localparam logic [3:0] WS = 4'(WIN_SCORE);

    typedef enum logic [2:0] {IDLE, ARM, RUN, HOLD, WIN} state_t;

    state_t      state, state_d;
    logic [2:0]  raw, s1, s2, ev;
    logic [1:0]  e, lockout, lockout_d;
    logic [31:0] tick, tick_d, period;
    logic [3:0]  level, level_d, score0, score0_d, score1, score1_d;
    logic        ptr, ptr_d, last, last_d, win, win_d, winner, winner_d, who, step;

    // bit 0 is the start button, bits 1/2 are players 0/1
    assign raw = {bus.btn_n, bus.start_n};

    // Two-flop synchronizer, idle level is released (high)
    always_ff @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end

    for (genvar g = 0; g < 3; g++) begin : g_db
        logic [DW-1:0] cnt;
        logic          down, pulse;
        assign ev[g] = pulse;
        // Accept a level change after DEBOUNCE stable cycles; pulse once on an accepted press
        always_ff @(posedge CLOCK or negedge RESET_N)
            if (!RESET_N) begin
                cnt   <= '0;
                down  <= 1'b0;
                pulse <= 1'b0;
            end else if (~s2[g] == down) begin
                cnt   <= '0;
                pulse <= 1'b0;
            end else if (cnt == DW'(DEBOUNCE - 1)) begin
                cnt   <= '0;
                down  <= ~s2[g];
                pulse <= ~s2[g];
            end else begin
                cnt   <= cnt + 1'b1;
                pulse <= 1'b0;
            end
    end

    // presses that still count this round; on a tie the pointer decides
    assign e      = ev[2:1] & ~lockout;
    assign who    = (&e) ? ptr : e[1];
    assign period = 32'(TICK_BASE) - 32'(level) * 32'(TICK_STEP);
    assign step   = (state == RUN) && (tick == period - 32'd1);

    assign bus.led_step    = step;
    assign bus.led_restart = state == ARM;
    assign bus.blink_mode  = state == IDLE;
    assign bus.level       = level;
    assign bus.score0      = score0;
    assign bus.score1      = score1;
    assign bus.win         = win;
    assign bus.winner      = winner;

    // State and round bookkeeping registers
    always_ff @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) begin
            state   <= IDLE;
            tick    <= '0;
            level   <= '0;
            score0  <= '0;
            score1  <= '0;
            lockout <= '0;
            ptr     <= 1'b0;
            last    <= 1'b0;
            win     <= 1'b0;
            winner  <= 1'b0;
        end else begin
            state   <= state_d;
            tick    <= tick_d;
            level   <= level_d;
            score0  <= score0_d;
            score1  <= score1_d;
            lockout <= lockout_d;
            ptr     <= ptr_d;
            last    <= last_d;
            win     <= win_d;
            winner  <= winner_d;
        end

    // Next-state logic: the tick counter doubles as the hold timer while in HOLD
    always_comb begin
        state_d   = state;
        tick_d    = tick;
        level_d   = level;
        score0_d  = score0;
        score1_d  = score1;
        lockout_d = lockout;
        ptr_d     = ptr;
        last_d    = last;
        win_d     = win;
        winner_d  = winner;
        case (state)
            IDLE: state_d = ev[0] ? ARM : IDLE;
            ARM: begin
                tick_d    = '0;
                lockout_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                tick_d = step ? '0 : tick + 32'd1;
                if ((|e) && bus.hit_zone) begin
                    state_d  = HOLD;
                    tick_d   = '0;
                    last_d   = who;
                    score0_d = who ? score0 : score0 + 4'd1;
                    score1_d = who ? score1 + 4'd1 : score1;
                    level_d  = (level == LVL_TOP) ? level : level + 4'd1;
`ifdef REACTION_TIE_ROUND_ROBIN_EN
                    ptr_d    = (&e) ? ~ptr : ptr;
`else
                    ptr_d    = 1'b0;
`endif
                end else if (|e) begin
                    lockout_d = lockout | e;
                    if (&(lockout | e)) begin
                        state_d = HOLD;
                        tick_d  = '0;
                    end
                end
            end
            HOLD: begin
                tick_d = tick + 32'd1;
                if (tick == 32'(HOLD_CYCLES - 1)) begin
                    tick_d = '0;
                    if (score0 == WS || score1 == WS) begin
                        state_d  = WIN;
                        win_d    = 1'b1;
                        winner_d = last;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            WIN: if (ev[0]) begin
                state_d  = IDLE;
                level_d  = '0;
                score0_d = '0;
                score1_d = '0;
                win_d    = 1'b0;
                winner_d = 1'b0;
                ptr_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_reaction_round_scheduler.sv
// tb_reaction_round_scheduler: randomized rounds against a score/level model with a scoreboard-driven output monitor.
module tb_reaction_round_scheduler;
    localparam int TB = 10, TS = 2, NL = 3, DB = 2, HC = 4, WS = 2;

    logic CLOCK = 1'b0;
    logic RESET_N = 1'b1;
    always #5 CLOCK = ~CLOCK;

    reaction_round_scheduler_if bus();

    reaction_round_scheduler #(
        .TICK_BASE(TB), .TICK_STEP(TS), .NUM_LEVELS(NL),
        .DEBOUNCE(DB), .HOLD_CYCLES(HC), .WIN_SCORE(WS)
    ) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0] lv, s0, s1;
        logic       w, wn;
        logic [1:0] kind;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   m_s[2];
    int   m_lv, m_ptr;
    bit   mon_en = 1'b0;

    task automatic chk(string nm, int got, int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic push(int kind, int w, int wn);
        exp_t x;
        x.lv   = 4'(m_lv);
        x.s0   = 4'(m_s[0]);
        x.s1   = 4'(m_s[1]);
        x.w    = 1'(w);
        x.wn   = 1'(wn);
        x.kind = 2'(kind);
        sb.push_back(x);
    endtask

    task automatic clr();
        m_s[0] = 0;
        m_s[1] = 0;
        m_lv   = 0;
        m_ptr  = 0;
    endtask

    task automatic score(int p);
        m_s[p]++;
        if (m_lv < NL - 1) m_lv++;
        push(0, 0, 0);
        if (m_s[p] == WS) push(1, 1, p);
    endtask

    task automatic cw(int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    // which: 0 restart pulse, 1 win raised, 2 win cleared
    task automatic wait_sig(string nm, int which);
        int k = 0;
        while (k < 300 && !((which == 0 && bus.led_restart) || (which == 1 && bus.win) ||
                            (which == 2 && !bus.win))) begin
            cw(1);
            k++;
        end
        chk(nm, int'(k < 300), 1);
    endtask

    task automatic press(logic [1:0] m, int n);
        bus.btn_n = ~m;
        cw(n);
        bus.btn_n = 2'b11;
    endtask

    task automatic round(int act);
        int p = int'($urandom_range(0, 1));
        int q = 1 - p;
        int w;
        cw(int'($urandom_range(3, 6)));
        case (act)
            0: begin
                bus.hit_zone = 1'b1;
                score(p);
                press(2'(1 << p), 6);
            end
            1: begin
`ifdef REACTION_TIE_ROUND_ROBIN_EN
                w = m_ptr;
                m_ptr = 1 - m_ptr;
`else
                w = 0;
`endif
                bus.hit_zone = 1'b1;
                score(w);
                press(2'b11, 6);
            end
            2: begin
                bus.hit_zone = 1'b0;
                press(2'(1 << p), 6);
                cw(5);
                bus.hit_zone = 1'b1;
                press(2'(1 << p), 6);
                cw(5);
                score(q);
                press(2'(1 << q), 6);
            end
            default: begin
                bus.hit_zone = 1'b0;
                press(2'(1 << p), 6);
                cw(5);
                press(2'(1 << q), 6);
            end
        endcase
        if (m_s[0] == WS || m_s[1] == WS) wait_sig("win_reached", 1);
        else wait_sig("next_round", 0);
    endtask

    task automatic start_match();
        bus.start_n = 1'b0;
        wait_sig("arm_after_start", 0);
        bus.start_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the display outputs change, checks sweep and hold timing
    logic [13:0] prev = '0, cur;
    exp_t        me;
    int          t_score = 0, last_ev = 0, mlv = 0;
    bit          hold_pend = 1'b0, run_live = 1'b0, rs_q = 1'b0;
    always @(negedge CLOCK) begin
        cyc++;
        if (mon_en) begin
            cur = {bus.level, bus.score0, bus.score1, bus.win, bus.winner};
            if (cur != prev) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_change: got %h expected %h (cycle %0d)", cur, prev, cyc);
                end else begin
                    me = sb.pop_front();
                    chk("outputs", int'(cur), int'({me.lv, me.s0, me.s1, me.w, me.wn}));
                    mlv = int'(me.lv);
                    run_live = 1'b0;
                    if (me.kind == 2'd0) begin
                        hold_pend = 1'b1;
                        t_score = cyc;
                    end else begin
                        if (me.kind == 2'd1 && hold_pend) chk("hold_to_win", cyc - t_score, HC);
                        hold_pend = 1'b0;
                    end
                end
                prev = cur;
            end
            if (bus.led_restart) begin
                chk("restart_single", int'(rs_q), 0);
                chk("blink_in_arm", int'(bus.blink_mode), 0);
                if (hold_pend) chk("hold_to_restart", cyc - t_score, HC);
                hold_pend = 1'b0;
                run_live = 1'b1;
                last_ev = cyc;
            end
            if (bus.led_step) begin
                if (hold_pend) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL step_in_hold: got step expected none (cycle %0d)", cyc);
                end else if (run_live) begin
                    chk("step_period", cyc - last_ev, TB - mlv * TS);
                end
                last_ev = cyc;
            end
            rs_q = bus.led_restart;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_n  = 1'b1;
        bus.btn_n    = 2'b11;
        bus.hit_zone = 1'b0;
        clr();
        #2 RESET_N = 1'b0;
        cw(3);
        chk("rst_step", int'(bus.led_step), 0);
        chk("rst_restart", int'(bus.led_restart), 0);
        chk("rst_blink", int'(bus.blink_mode), 1);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_score0", int'(bus.score0), 0);
        chk("rst_score1", int'(bus.score1), 0);
        chk("rst_win", int'(bus.win), 0);
        chk("rst_winner", int'(bus.winner), 0);
        RESET_N = 1'b1;
        mon_en = 1'b1;
        cw(3);
        for (int m = 0; m < 4; m++) begin
            start_match();
            if (m == 0) begin
                bus.hit_zone = 1'b1;
                cw(3);
                bus.btn_n[0] = 1'b0;
                cw(1);
                bus.btn_n[0] = 1'b1;
                cw(8);
            end
            for (int r = 0; r < 60 && m_s[0] < WS && m_s[1] < WS; r++)
                round((m == 0 && r < 2) ? 1 : (m == 1 && r == 0) ? 2 : int'($urandom_range(0, 3)));
            clr();
            push(2, 0, 0);
            bus.start_n = 1'b0;
            wait_sig("win_cleared", 2);
            bus.start_n = 1'b1;
            cw(1);
            chk("blink_idle", int'(bus.blink_mode), 1);
            cw(5);
        end
        start_match();
        round(0);
        cw(3);
        clr();
        push(2, 0, 0);
        RESET_N = 1'b0;
        cw(2);
        chk("midrun_rst_step", int'(bus.led_step), 0);
        chk("midrun_rst_restart", int'(bus.led_restart), 0);
        chk("midrun_rst_blink", int'(bus.blink_mode), 1);
        RESET_N = 1'b1;
        cw(10);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
